rtio_event_scheduler: RTL and testbench



---
 rtl/rtio_pkg.sv | 18 +
 rtl/rtio_event_fifo.sv | 54 +++++
 rtl/rtio_event_scheduler.sv | 114 +++++++++++
 tb/tb_rtio_event_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtio_pkg.sv
// Shared RTIO types: timestamp width, event record and error codes.
package rtio_pkg;

    localparam int TS_WIDTH   = 64;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic [TS_WIDTH-1:0]   timestamp;
        logic [DATA_WIDTH-1:0] data;
    } rtio_event_t;

    typedef enum logic [1:0] {
        NONE,
        UNDERFLOW,
        SEQUENCE
    } rtio_err_e;

endpackage

// File: rtl/rtio_event_fifo.sv
// First-word-fall-through FIFO with registered occupancy count and synchronous flush.
module rtio_event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rtio_event_scheduler.sv
// Releases queued (timestamp, data) events as one-cycle strobes when counter matches.
// Optional RTIO_SCHED_SEQ_CHECK_EN rejects non-increasing timestamps.
module rtio_event_scheduler #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 64
) (
    input  logic                       rtio_clk,
    input  logic                       reset,
    input  logic [TS_WIDTH-1:0]        counter,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [TS_WIDTH-1:0]        wr_timestamp,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       flush,
    input  logic                       clear_error,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       underflow_error,
    output logic                       sequence_error
);

    import rtio_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fire;
    logic                  late;
    logic                  seq_reject;
    logic [TS_WIDTH-1:0]   head_ts;
    logic [DATA_WIDTH-1:0] head_data;
    rtio_err_e             head_err;

    rtio_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_WIDTH + DATA_WIDTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (rtio_clk),
        .rst       (reset),
        .push      (push),
        .push_data ({wr_timestamp, wr_data}),
        .pop       (pop),
        .flush     (flush),
        .head_data ({head_ts, head_data}),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Full blocks writes even when a pop lands in the same cycle.
    assign wr_ready = !full && !flush;
    assign accept   = wr_valid && wr_ready;
    assign push     = accept && !seq_reject;
    assign fire     = !flush && !empty && (head_ts == counter);
    assign late     = !flush && !empty && (head_ts < counter);
    assign pop      = fire || late;
    assign head_err = late ? UNDERFLOW : NONE;

    always_ff @(posedge rtio_clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= fire;
            if (fire) out_data <= head_data;
        end
    end

    always_ff @(posedge rtio_clk or posedge reset) begin
        if (reset)                        underflow_error <= 1'b0;
        else if (head_err == UNDERFLOW)   underflow_error <= 1'b1;
        else if (clear_error)             underflow_error <= 1'b0;
    end

`ifdef RTIO_SCHED_SEQ_CHECK_EN
    logic [TS_WIDTH-1:0] last_ts;
    logic                have_last;
    rtio_err_e           wr_err;

    // The first write after reset/flush has nothing to be ordered against.
    assign seq_reject = have_last && (wr_timestamp <= last_ts);
    assign wr_err     = (accept && seq_reject) ? SEQUENCE : NONE;

    always_ff @(posedge rtio_clk or posedge reset) begin
        if (reset) begin
            last_ts   <= '0;
            have_last <= 1'b0;
        end else if (flush) begin
            last_ts   <= '0;
            have_last <= 1'b0;
        end else if (push) begin
            last_ts   <= wr_timestamp;
            have_last <= 1'b1;
        end
    end

    always_ff @(posedge rtio_clk or posedge reset) begin
        if (reset)                     sequence_error <= 1'b0;
        else if (wr_err == SEQUENCE)   sequence_error <= 1'b1;
        else if (clear_error)          sequence_error <= 1'b0;
    end
`else
    assign seq_reject     = 1'b0;
    assign sequence_error = 1'b0;
`endif

endmodule

// File: tb/tb_rtio_event_scheduler.sv
// Directed plus randomized bench for rtio_event_scheduler against a queue-based event model.
module tb_rtio_event_scheduler;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int TW    = 64;
    localparam int CW    = 5;
`ifdef RTIO_SCHED_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic          rtio_clk = 1'b0;
    logic          reset = 1'b1;
    logic [TW-1:0] counter = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [TW-1:0] wr_timestamp = '0;
    logic [DW-1:0] wr_data = '0;
    logic          flush = 1'b0;
    logic          clear_error = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] fifo_count;
    logic          underflow_error;
    logic          sequence_error;

    always #5 rtio_clk = ~rtio_clk;

    rtio_event_scheduler #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TS_WIDTH(TW)) dut (
        .rtio_clk        (rtio_clk),
        .reset           (reset),
        .counter         (counter),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_timestamp    (wr_timestamp),
        .wr_data         (wr_data),
        .flush           (flush),
        .clear_error     (clear_error),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .fifo_count      (fifo_count),
        .underflow_error (underflow_error),
        .sequence_error  (sequence_error)
    );

    typedef struct {
        logic [TW-1:0] ts;
        logic [DW-1:0] d;
    } ev_t;

    ev_t           q[$];
    logic [TW-1:0] m_last;
    bit            m_have, m_uf, m_seq, m_ov;
    logic [DW-1:0] m_od;
    int            checks = 0;
    int            failures = 0;
    int            strobes = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_have = 0; m_last = '0;
        m_uf = 0; m_seq = 0; m_ov = 0; m_od = '0;
    endtask

    // One clock edge of the event rules, applied to the inputs currently driven.
    task automatic model_edge();
        bit uf_set = 0, seq_set = 0;
        int n = q.size();
        ev_t e;
        m_ov = 0;
        if (flush) begin
            q.delete();
            m_have = 0;
        end else begin
            if (n > 0) begin
                if (q[0].ts == counter) begin
                    m_ov = 1; m_od = q[0].d; e = q.pop_front();
                end else if (q[0].ts < counter) begin
                    uf_set = 1; e = q.pop_front();
                end
            end
            if (wr_valid && n < DEPTH) begin
                if (SEQ && m_have && wr_timestamp <= m_last) seq_set = 1;
                else begin
                    e.ts = wr_timestamp; e.d = wr_data;
                    q.push_back(e);
                    m_last = wr_timestamp; m_have = 1;
                end
            end
        end
        if (uf_set) m_uf = 1; else if (clear_error) m_uf = 0;
        if (seq_set) m_seq = 1; else if (clear_error) m_seq = 0;
    endtask

    task automatic tick();
        #1;
        chk("wr_ready", wr_ready, (q.size() < DEPTH) && !flush);
        model_edge();
        @(posedge rtio_clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) chk("out_data", out_data, m_od);
        chk("fifo_count", fifo_count, 64'(q.size()));
        chk("underflow_error", underflow_error, m_uf);
        chk("sequence_error", sequence_error, m_seq);
        if (out_valid) strobes++;
    endtask

    task automatic idle();
        wr_valid = 0; flush = 0; clear_error = 0;
    endtask

    task automatic wr(input logic [TW-1:0] ts, input logic [DW-1:0] d);
        wr_valid = 1; wr_timestamp = ts; wr_data = d;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_underflow"}, underflow_error, 0);
        chk({tag, "_sequence"}, sequence_error, 0);
        chk({tag, "_wr_ready"}, wr_ready, 1);
    endtask

    initial begin
        int s0;
        logic [TW-1:0] base;
        model_reset();
        #1;
        reset_values("reset");
        @(posedge rtio_clk); @(posedge rtio_clk); #1;
        reset = 0;

        // Fire on time
        s0 = strobes;
        for (int c = 0; c <= 14; c++) begin
            counter = TW'(c);
            if (c == 2) wr(10, 32'hA); else idle();
            tick();
        end
        chk("t1_strobes", 64'(strobes - s0), 1);

        // Late event, then clear
        counter = 100; wr(50, 32'h55); tick();
        idle(); tick(); tick();
        chk("t2_underflow", underflow_error, 1);
        clear_error = 1; tick();
        idle(); tick();
        chk("t2_cleared", underflow_error, 0);

        // Burst to full with counter stalled, then release
        counter = 0;
        for (int i = 0; i < 16; i++) begin
            wr(TW'(20 + i), DW'(32'h100 + i)); tick();
        end
        idle(); tick();
        chk("t3_full_count", fifo_count, 16);
        chk("t3_full_ready", wr_ready, 0);
        wr(99, 32'hDEAD); tick();
        idle();
        s0 = strobes;
        for (int c = 1; c <= 40; c++) begin
            counter = TW'(c); tick();
        end
        chk("t3_strobes", 64'(strobes - s0), 16);

        // Sequence check
        flush = 1; clear_error = 1; tick();
        idle(); counter = 0;
        wr(40, 32'hB1); tick();
        wr(40, 32'hB2); tick();
        idle();
        s0 = strobes;
        for (int c = 1; c <= 45; c++) begin
            counter = TW'(c); tick();
        end
        chk("t4_strobes", 64'(strobes - s0), 1);
        chk("t4_seq_flag", sequence_error, SEQ);
        chk("t4_uf_flag", underflow_error, !SEQ);

        // Flush with a simultaneous write
        clear_error = 1; counter = 0; tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            wr(TW'(1000 + i), DW'(i)); tick();
        end
        flush = 1; wr(2000, 32'hF00); tick();
        chk("t5_flush_count", fifo_count, 0);
        idle();
        s0 = strobes;
        for (int c = 998; c <= 1004; c++) begin
            counter = TW'(c); tick();
        end
        counter = 2000; tick();
        chk("t5_no_strobes", 64'(strobes - s0), 0);

        // Asynchronous reset in the middle of a strobe burst
        counter = 0;
        for (int i = 0; i < 4; i++) begin
            wr(TW'(10 + i), DW'(32'hC0 + i)); tick();
        end
        idle();
        counter = 10; tick();
        counter = 11; tick();
        chk("t6_pre_reset_strobe", out_valid, 1);
        #1 reset = 1;
        #1;
        model_reset();
        reset_values("midreset");
        @(posedge rtio_clk); #1;
        reset = 0;

        // Randomized traffic
        counter = 0;
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) counter = 0;
            else if (r >= 15) counter = counter + 1;
            wr_valid = $urandom_range(0, 1);
            base = counter + TW'($urandom_range(0, 14));
            wr_timestamp = (base >= 2) ? base - 2 : base;
            wr_data = $urandom;
            flush = ($urandom_range(0, 99) < 3);
            clear_error = ($urandom_range(0, 99) < 8);
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
